// File: rtl/pico_pkg.sv
// Shared PicoMIPS core types and widths.
package pico;
  localparam int A     = 10;
  localparam int W_IMM = 8;

  // RETURN sits at 2'h0, so the decoder must drive PC_INC for ordinary instructions.
  typedef enum logic [1:0] {PC_RET = 2'h0, PC_INC = 2'h1, PC_REL = 2'h2, PC_SUB = 2'h3} modePC;

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} statePC;
endpackage

// File: rtl/pico_pc_unit_if.sv
// Decoder <-> PC unit bundle: control requests in, fetch address and status out.
interface pico_pc_unit_if #(
  parameter int A     = pico::A,
  parameter int IW    = pico::W_IMM,
  parameter int DEPTH = 4
);
  import pico::*;
  localparam int DW = $clog2(DEPTH+1);

  modePC          mode;
  logic [IW-1:0]  imm;
  logic           halt_req;
  logic           wfi_req;
  logic           irq;
  logic [A-1:0]   pc;
  logic           stall;
  logic           halted;
  logic           stack_err;
  logic [DW-1:0]  depth;

  modport master (output mode, imm, halt_req, wfi_req, irq,
                  input  pc, stall, halted, stack_err, depth);
  modport slave  (input  mode, imm, halt_req, wfi_req, irq,
                  output pc, stall, halted, stack_err, depth);
endinterface

// File: rtl/pico_ret_stack.sv
// Return-address stack; push on full and pop on empty are silently ignored here.
module pico_ret_stack #(
  parameter int A     = pico::A,
  parameter int DEPTH = 4,
  localparam int DW   = $clog2(DEPTH+1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [A-1:0]  din,
  output logic [A-1:0]  dout,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);
  logic [DEPTH-1:0][A-1:0] mem;
  logic [DW-1:0]           cnt;
  logic [DW-1:0]           top;

  assign top   = cnt - DW'(1);
  assign dout  = mem[top[AW-1:0]];
  assign depth = cnt;
  assign full  = (cnt == DW'(DEPTH));
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      if (push && !full) begin
        mem[cnt[AW-1:0]] <= din;
        cnt              <= cnt + DW'(1);
      end else if (pop && !empty) begin
        cnt <= cnt - DW'(1);
      end
    end
  end

  always_ff @(posedge clk)
    if (!rst) assert (!(push && pop)) else $error("pico_ret_stack: push and pop together");
endmodule

// File: rtl/pico_pc_unit.sv
// PC register, RUN/WAIT/HALT sequencing and sticky stack error flag.
module pico_pc_unit #(
  parameter int A     = pico::A,
  parameter int IW    = pico::W_IMM,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  pico_pc_unit_if.slave  bus
);
  import pico::*;
  localparam int DW = $clog2(DEPTH+1);

  statePC        st_q, st_d;
  logic [A-1:0]  pc_q, pc_d;
  logic          err_q, err_d;
  logic          push, pop, full, empty;
  logic [A-1:0]  top;
  logic [A-1:0]  pc_inc;

  assign pc_inc = pc_q + A'(1);

  pico_ret_stack #(.A(A), .DEPTH(DEPTH)) u_stack (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(pc_inc),
    .dout(top), .depth(bus.depth), .full(full), .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= S_RUN;
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    case (st_q)
      S_RUN: begin
        if (bus.halt_req)     st_d = S_HALT;
        else if (bus.wfi_req) st_d = S_WAIT;
        else begin
          case (bus.mode)
            PC_INC: pc_d = pc_inc;
            PC_REL: pc_d = pc_q + {{(A-IW){bus.imm[IW-1]}}, bus.imm};
            PC_SUB: begin
              push = 1'b1;
              pc_d = {{(A-IW){1'b0}}, bus.imm};
              if (full) err_d = 1'b1;
            end
            default: begin
              // Underflow falls through as a plain increment.
              if (empty) begin
                pc_d  = pc_inc;
                err_d = 1'b1;
              end else begin
                pop  = 1'b1;
                pc_d = top;
              end
            end
          endcase
        end
      end
      S_WAIT: begin
        if (bus.irq) begin
          st_d = S_RUN;
          pc_d = pc_inc;
        end
      end
      default: ;
    endcase
  end

  assign bus.pc        = pc_q;
  assign bus.stall     = (st_q != S_RUN);
  assign bus.halted    = (st_q == S_HALT);
  assign bus.stack_err = err_q;
endmodule

// File: doc/pico_pc_unit.md
# pico_pc_unit

Program-counter unit of the PicoMIPS core. It sits directly upstream of instruction fetch: each cycle it drives the program memory address. From the decoder it consumes a resolved `modePC`, the 8-bit immediate, and halt/WFI requests. It holds a small hardware return-address stack for `JSBR`/`RSBR`, and a RUN/WAIT/HALT state machine that implements `O_HALT` and `O_WFI`.

## Interface
Parameters:
- `A`, default `pico::A` (10), PC / program-address width
- `IW`, default `pico::W_IMM` (8), immediate width
- `DEPTH`, default 4, return-stack entries (≥1)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `mode`  in  2  `pico::modePC`; sampled only in RUN
- `imm`  in  `IW`  signed offset (RELATIVE) or unsigned target (SUBROUTINE)
- `halt_req`  in  1  decoder saw `O_HALT`
- `wfi_req`  in  1  decoder saw `O_WFI`
- `irq`  in  1  level-sensitive wake from WAIT
- `pc`  out  `A`  registered program address
- `stall`  out  1  high in WAIT or HALT (PC frozen)
- `halted`  out  1  high in HALT
- `stack_err`  out  1  sticky overflow/underflow flag
- `depth`  out  `$clog2(DEPTH+1)`  current return-stack occupancy

## Operation
- Reset values: `pc`=0, state RUN, `stall`=0, `halted`=0, `stack_err`=0, `depth`=0. Stack contents are don't-care.
- Request priority in RUN: `halt_req` > `wfi_req` > `mode`.
- `halt_req` in RUN → HALT. `pc` holds, and stack and error state are unchanged. Only `rst` leaves HALT.
- `wfi_req` in RUN → WAIT, with `pc` holding the WFI address.
- In WAIT with `irq`=1 → RUN, with `pc` <= `pc`+1. `mode`, `halt_req` and `wfi_req` are ignored while in WAIT.
- RUN, `mode` handling:
  - INCREMENT: `pc` <= `pc`+1.
  - RELATIVE: `pc` <= `pc` + sign-extend(`imm`).
  - SUBROUTINE: push `pc`+1, then `pc` <= zero-extend(`imm`).
  - RETURN: pop, then `pc` <= popped value.
- All PC arithmetic is modulo 2^`A`; wrap-around is silent (0x3FF+1 → 0x000, 0x000 + (−1) → 0x3FF).
- Push when `depth`==`DEPTH`: the entry is discarded, the jump is still taken, `stack_err` is set, and `depth` is unchanged.
- Pop when `depth`==0: `pc` <= `pc`+1, `stack_err` is set, and `depth` stays 0.
- `stack_err` clears only on `rst`.
- The decoder must drive INCREMENT for all non-control instructions. This is required because RETURN is encoded as 2'h0.

## Timing
- Registered output: `mode`/`imm` sampled at edge N take effect on `pc` after edge N, so latency is one cycle. There is no combinational path from inputs to `pc`.
- `stall` and `halted` are decoded from registered state only.
  - `stall` rises in the cycle after the request is sampled.
  - `stall` falls in the cycle after `irq` is sampled high.
- `wfi_req` and `irq` high in the same RUN cycle: enter WAIT anyway. If `irq` is still high at the next edge, return to RUN (minimum WAIT residency is 1 cycle).
- Push and pop complete in the same cycle as the `pc` update, so back-to-back JSBR/RSBR are legal every cycle.
- `rst` asserted in any state, including mid-WAIT or with a full stack, takes priority over everything and restores all reset values at the next edge.

## Structure
- Add `typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} statePC;` to package `pico`. Reuse `modePC`, `A` and `W_IMM` from there.
- Sub-module `pico_ret_stack`:
  - Parameters: `A`, `DEPTH`.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `dout` (top of stack), `depth`, `full`, `empty`.
  - Register array with pointer; mutually exclusive push/pop asserted.
- The top level holds the FSM, PC register and error flag.

## Test plan
- Reset, then INCREMENT ×5 → `pc` sequence 1,2,3,4,5; `stall`=0; `depth`=0.
- `pc`=0x010, RELATIVE `imm`=0xFE → `pc`=0x00E. Then `pc`=0x3FF, INCREMENT → `pc`=0x000.
- Return stack round trip:
  - At `pc`=0x005, SUBROUTINE `imm`=0x20 → `pc`=0x020, `depth`=1.
  - INCREMENT ×2 → `pc`=0x022.
  - RETURN → `pc`=0x006, `depth`=0.
- Overflow and underflow:
  - 5 consecutive SUBROUTINE (`DEPTH`=4) → `depth`=4, `stack_err`=1 after the 5th; 4 RETURNs unwind in LIFO order.
  - A 5th RETURN → `pc`+1, `stack_err` stays 1.
- WFI:
  - `wfi_req` at `pc`=0x007 → `stall`=1 and `pc`=0x007 held for 10 cycles with `irq`=0.
  - `irq`=1 → next cycle `pc`=0x008, `stall`=0.
- `halt_req` together with `wfi_req` and `mode`=SUBROUTINE → HALT, `pc` unchanged, `depth` unchanged. `irq` ignored; `rst` → `pc`=0, `halted`=0.
